// File: rtl/scr1_dmem_dma_if.sv
// SCR1 dmem-style bus bundle between an initiator (master) and a responder (slave).
interface scr1_dmem_dma_if #(
   parameter int AW = 32
);
   logic          req;
   logic          cmd;
   logic [1:0]    width;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          req_ack;
   logic [31:0]   rdata;
   logic [1:0]    resp;

   modport master (
      output req, cmd, width, addr, wdata,
      input  req_ack, rdata, resp
   );

   modport slave (
      input  req, cmd, width, addr, wdata,
      output req_ack, rdata, resp
   );
endinterface

// File: rtl/scr1_dmem_dma.sv
// Single-channel word copy/fill engine mastering an SCR1 dmem-style bus.
// One transaction is outstanding at a time; copy does RD then WR per word,
// fill does WR only. A bus error aborts the transfer and is reported sticky.
module scr1_dmem_dma #(
   parameter int LEN_W = 16,
   parameter int AW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_mode,
   input  logic [AW-1:0]    cfg_src_addr,
   input  logic [AW-1:0]    cfg_dst_addr,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [31:0]      cfg_pattern,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [AW-1:0]    err_addr,
   scr1_dmem_dma_if.master  dmem
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_FIN
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             mode_r;
   logic [AW-1:0]    src_r;
   logic [AW-1:0]    dst_r;
   logic [LEN_W-1:0] cnt_r;
   logic [31:0]      data_r;
   logic [AW-1:0]    cur_addr;
   logic             start_acc;
   logic             resp_ok;
   logic             resp_er;
   logic             in_wait;

   assign start_acc = (state == ST_IDLE) && cfg_start;
   assign resp_ok   = (dmem.resp == 2'b01);
   // Both RDY_ER (10) and the undefined code 11 abort the transfer.
   assign resp_er   = dmem.resp[1];
   assign in_wait   = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);

   assign dmem.width = 2'b10;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: request phases wait for ack, wait phases for a response.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cfg_start) begin
               if (cfg_len == '0)  state_nxt = ST_FIN;
               else if (cfg_mode)  state_nxt = ST_WR_REQ;
               else                state_nxt = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (dmem.req_ack) state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (resp_er)      state_nxt = ST_FIN;
            else if (resp_ok) state_nxt = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            if (dmem.req_ack) state_nxt = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (resp_er) begin
               state_nxt = ST_FIN;
            end else if (resp_ok) begin
               if (cnt_r == LEN_W'(1)) state_nxt = ST_FIN;
               else if (mode_r)        state_nxt = ST_WR_REQ;
               else                    state_nxt = ST_RD_REQ;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus and status outputs decoded from the current state and registers.
   always_comb begin
      cur_addr   = '0;
      dmem.req   = 1'b0;
      dmem.cmd   = 1'b0;
      dmem.wdata = 32'h0;
      busy       = (state != ST_IDLE);
      done       = (state == ST_FIN);
      case (state)
         ST_RD_REQ, ST_RD_WAIT: begin
            cur_addr = src_r;
            dmem.req = (state == ST_RD_REQ);
         end
         ST_WR_REQ, ST_WR_WAIT: begin
            cur_addr   = dst_r;
            dmem.req   = (state == ST_WR_REQ);
            dmem.cmd   = 1'b1;
            dmem.wdata = data_r;
         end
         default: begin
            cur_addr = '0;
         end
      endcase
      dmem.addr = cur_addr;
   end

   // Transfer registers: latch config on start, advance pointers per completed
   // write, capture read data, record the failing address on an error.
   // In fill mode the data register simply holds the pattern for every write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r   <= 1'b0;
         src_r    <= '0;
         dst_r    <= '0;
         cnt_r    <= '0;
         data_r   <= 32'h0;
         error    <= 1'b0;
         err_addr <= '0;
      end else begin
         if (start_acc) begin
            mode_r   <= cfg_mode;
            src_r    <= cfg_src_addr & ~AW'(3);
            dst_r    <= cfg_dst_addr & ~AW'(3);
            cnt_r    <= cfg_len;
            data_r   <= cfg_pattern;
            error    <= 1'b0;
            err_addr <= '0;
         end else if (in_wait && resp_er) begin
            error    <= 1'b1;
            err_addr <= cur_addr;
         end else if ((state == ST_RD_WAIT) && resp_ok) begin
            data_r <= dmem.rdata;
         end else if ((state == ST_WR_WAIT) && resp_ok) begin
            cnt_r <= cnt_r - LEN_W'(1);
            src_r <= src_r + AW'(4);
            dst_r <= dst_r + AW'(4);
         end
      end
   end

endmodule

// File: doc/scr1_dmem_dma.md
Name: scr1_dmem_dma

Overview:
- Single-channel word-copy/fill engine acting as initiator (master) on an SCR1 dmem-style interface.
- Pairs with TCM or any dmem responder.
- Software-side control loads src/dst/length and pulses start. Engine moves words one transaction at a time and reports done/error.
- Used for TCM preload, clearing and scrubbing without core involvement.

Parameters:
- LEN_W, 16, width of word-count field; max transfer = 2^LEN_W-1 words.
- AW, 32, dmem address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_mode  in  1  0=copy src->dst, 1=fill dst with cfg_pattern
- cfg_src_addr  in  AW  source byte address; bits[1:0] ignored
- cfg_dst_addr  in  AW  destination byte address; bits[1:0] ignored
- cfg_len  in  LEN_W  transfer length in 32-bit words
- cfg_pattern  in  32  fill data
- busy  out  1  high from accepted start until done pulse inclusive
- done  out  1  one-cycle completion pulse (normal or abort)
- error  out  1  sticky; set on RDY_ER, cleared by next accepted start
- err_addr  out  AW  address of failing transaction
- dmem_req  out  1  request
- dmem_cmd  out  1  0=RD, 1=WR
- dmem_width  out  2  always 2'b10 (WORD)
- dmem_addr  out  AW  word-aligned address
- dmem_wdata  out  32  write data
- dmem_req_ack  in  1  responder accepts request this cycle
- dmem_rdata  in  32  read data, valid with resp
- dmem_resp  in  2  00=NOTRDY, 01=RDY_OK, 10=RDY_ER

Behaviour:
- Reset: FSM=IDLE; all outputs 0 (dmem_width=2'b10 constant); internal counters and data register cleared.
- Start:
  - cfg_start in IDLE latches all cfg_* inputs, clears error, sets busy next cycle.
  - cfg_start while busy is ignored.
  - cfg_len=0: no bus traffic; done pulses in the cycle after start, then IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
  - Copy mode starts in RD_REQ.
  - Fill mode starts in WR_REQ and never enters RD_*.
- Request phase (RD_REQ/WR_REQ):
  - dmem_req=1; cmd/addr/wdata driven from registers and held stable until a cycle with dmem_req_ack=1.
  - On that edge, advance to the matching *_WAIT state.
- Wait phase:
  - dmem_req=0; exactly one outstanding transaction.
  - NOTRDY: stay.
  - RD_WAIT + RDY_OK: capture dmem_rdata into the data register; go to WR_REQ.
  - WR_WAIT + RDY_OK:
    - Decrement count; src+=4, dst+=4 (mod 2^AW).
    - count becomes 0 -> FIN.
    - Otherwise go to RD_REQ (copy) or WR_REQ (fill).
  - RDY_ER (either wait state): error=1, err_addr=current dmem_addr, go to FIN; remaining words are skipped.
  - Resp value 11 is treated as RDY_ER.
- FIN: done=1 for one cycle, busy stays 1 this cycle; next state IDLE.
- Throughput with an always-ack, next-cycle-resp responder (TCM):
  - Copy: 4 cycles/word.
  - Fill: 2 cycles/word.
  - done is asserted 1 cycle after the final write response.
- Async reset mid-transfer: immediate return to reset values. Any in-flight response arriving after reset is ignored.

Test Plan:
- Copy 4 words, src=0x100 (preloaded 0x11111111..0x44444444), dst=0x200, TCM responder -> reads 0x100/104/108/10C and writes 0x200/204/208/20C in the same order; dst holds the same data; done at cycle 17 after start; error=0.
- Fill len=3, dst=0x40, pattern=0xDEADBEEF -> three WR requests to 0x40/44/48 with wdata 0xDEADBEEF, no RD; done 7 cycles after start.
- Backpressure: req_ack held low 3 cycles on the second read -> req stays high with dmem_addr=0x104 stable for all 4 cycles; data still correct; total +3 cycles.
- Error: responder returns RDY_ER on the write to 0x208 of a 4-word copy -> error=1, err_addr=0x208, no access to 0x10C/0x20C, done pulses once; a following start clears error.
- len=0 start -> zero dmem_req cycles, done one cycle after start. cfg_start pulsed while busy -> ignored, counts unchanged.
- Unaligned src=0x103 copy 1 word -> dmem_addr=0x100. rst_n asserted during RD_WAIT -> req=0, busy=0, done=0 immediately; a late RDY_OK is ignored.
